ppwm_cfg_master: RTL and testbench
==================================

# ppwm_cfg_master

Bus initiator that drives the servo PWM peripheral's register interface (`cs`, `wr`, `rd`, `addr`, `d_in`) from a simple command stream. Each accepted command becomes exactly one framed write or read cycle on the peripheral bus. Read data and an error flag come back on a one-cycle response strobe. It sits between the cube-solver control logic (or a UART command parser) and the 8-servo PWM block. It replaces hand-driven bus stimulus.

## Interface
- `STROBE_CYCLES`, default 2: cycles `wr`/`rd` stay high per transaction; legal range 1..16.
- `ADDR_LIMIT`, default 8'h1C: highest legal register address (8 servos × 4 bytes).

Ports:
- `clk`  in  1: single clock. Everything is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  8: register byte address.
- `cmd_data`  in  32: write data. Ignored for reads.
- `rsp_valid`  out  1: one-cycle response pulse.
- `rsp_err`  out  1: command rejected. Qualified by `rsp_valid`.
- `rsp_data`  out  32: read data. 0 for writes and errors.
- `cs`  out  1: peripheral chip select.
- `wr`  out  1: peripheral write strobe.
- `rd`  out  1: peripheral read strobe.
- `addr`  out  8: peripheral address.
- `d_out`  out  32: data to peripheral. Connects to peripheral `d_in`.
- `d_in`  in  32: read data from peripheral.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - `cmd_ready`=1; all bus outputs 0.
  - Accept when `cmd_valid & cmd_ready`; latch write flag, address and data.
  - Legal command (`cmd_addr[1:0]==0` and `cmd_addr<=ADDR_LIMIT`): go to SETUP.
  - Illegal command: go to RESP with error set; no bus activity.
- SETUP (1 cycle): `cs`=1, `addr` and `d_out` driven from latches, `wr`=`rd`=0. `d_out`=0 for reads.
- STROBE (`STROBE_CYCLES` cycles): `cs`=1, addr/data held, `wr`=1 for writes or `rd`=1 for reads.
  - 4-bit down-counter loaded with `STROBE_CYCLES-1` on entry.
  - Exit when the counter reaches 0.
  - Reads capture `d_in` into `rsp_data` at the edge ending the last STROBE cycle.
- HOLD (1 cycle): `cs`=1, `wr`=`rd`=0, addr/data held.
- RESP (1 cycle): bus outputs 0, `rsp_valid`=1, `rsp_err` = latched error, then back to IDLE.
- `rsp_data` and `rsp_err` keep their values until the next RESP. `rsp_data` is cleared to 0 when a write or error response is issued.
- `cmd_ready`=0 in every state except IDLE. No command queuing.
- `wr` and `rd` are never high together.
- `wr`/`rd` is never high unless `cs` is high.
- `addr` and `d_out` never change while `cs`=1.

## Timing
- Reset values: `cmd_ready`=0 while `reset`=1, then 1 from the first cycle after deassertion. `rsp_valid`, `rsp_err`, `rsp_data`, `cs`, `wr`, `rd`, `addr`, `d_out` are all 0.
- With N = `STROBE_CYCLES` and the accept edge ending cycle k:
  - SETUP is cycle k+1.
  - STROBE is cycles k+2..k+1+N.
  - HOLD is cycle k+2+N.
  - `rsp_valid` is high in cycle k+3+N.
  - `cmd_ready` returns to 1 in cycle k+4+N.
- Error path: `rsp_valid`/`rsp_err` high in cycle k+1; `cmd_ready`=1 in cycle k+2.
- Back-to-back commands (`cmd_valid` held high): accepts are 4+N cycles apart, or 2 cycles apart for errors.
- Reset mid-transaction (any state): at the next edge the FSM goes to IDLE and all outputs take their reset values. `cs`/`wr`/`rd` drop in the cycle after reset is sampled. No response is issued for the aborted command.
- `cmd_*` inputs are sampled only at the accept edge. Changes afterwards have no effect.

## Test plan
- Write with N=2: `cmd_addr`=8'h00, `cmd_data`=1 accepted at k.
  - Bus: `cs`=1 in cycles k+1..k+4; `wr`=1 in k+2..k+3; `addr`=0 and `d_out`=1 stable throughout.
  - Response: `rsp_valid` in k+5 with `rsp_err`=0 and `rsp_data`=0.
- Read: `cmd_addr`=8'h04 with peripheral `d_in`=32'd20.
  - Bus: `rd`=1 in k+2..k+3; `wr` stays 0.
  - Response: `rsp_valid` in k+5 with `rsp_data`=20.
- Illegal addresses: 8'h06 (misaligned) and then 8'h20 (above limit).
  - Each gets `rsp_valid`+`rsp_err`=1 one cycle after accept.
  - `cs` never rises.
- Back-to-back with N=3: writes to 8'h08 and then 8'h0C with `cmd_valid` held.
  - Second accept comes exactly 7 cycles after the first.
  - Between the two transactions, `cs` is low for at least 2 cycles (RESP and IDLE).
- Reset asserted during the second STROBE cycle.
  - Next cycle: `cs`=`wr`=0 and no `rsp_valid`.
  - `cmd_ready`=1 in the first cycle after reset deasserts.
  - A following write to 8'h00 completes normally.

Source files
------------

// File: rtl/ppwm_cfg_master.sv
// Bus initiator for the servo PWM register interface: turns one accepted command
// into one framed SETUP/STROBE/HOLD cycle on cs/wr/rd, then pulses a response.
module ppwm_cfg_master #(
  parameter int          STROBE_CYCLES = 2,
  parameter logic [7:0]  ADDR_LIMIT    = 8'h1C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_data,
  output logic        cs,
  output logic        wr,
  output logic        rd,
  output logic [7:0]  addr,
  output logic [31:0] d_out,
  input  logic [31:0] d_in
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_write;
  logic [7:0]  r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_cnt;
  logic        r_rsp_err;
  logic [31:0] r_rsp_data;
  logic        w_accept;
  logic        w_legal;
  logic        w_last;

  assign w_legal  = (cmd_addr[1:0] == 2'b00) && (cmd_addr <= ADDR_LIMIT);
  assign w_last   = (r_state == S_STROBE) && (r_cnt == 4'd0);
  assign rsp_err  = r_rsp_err;
  assign rsp_data = r_rsp_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first; a missing branch
  // assignment would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    cs        = 1'b0;
    wr        = 1'b0;
    rd        = 1'b0;
    addr      = '0;
    d_out     = '0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = ~reset;
        w_accept  = cmd_valid & ~reset;
        if (w_accept) w_next = w_legal ? S_SETUP : S_RESP;
      end
      S_SETUP: begin
        cs     = 1'b1;
        addr   = r_addr;
        d_out  = r_data;
        w_next = S_STROBE;
      end
      S_STROBE: begin
        cs    = 1'b1;
        addr  = r_addr;
        d_out = r_data;
        wr    = r_write;
        rd    = ~r_write;
        if (r_cnt == 4'd0) w_next = S_HOLD;
      end
      S_HOLD: begin
        cs     = 1'b1;
        addr   = r_addr;
        d_out  = r_data;
        w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latches, strobe counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_data  <= cmd_write ? cmd_data : '0;
        if (!w_legal) begin
          r_rsp_err  <= 1'b1;
          r_rsp_data <= '0;
        end
      end
      if (r_state == S_SETUP)
        r_cnt <= 4'(STROBE_CYCLES - 1);
      else if (r_state == S_STROBE && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_last && !r_write)
        r_rsp_data <= d_in;
      if (r_state == S_HOLD) begin
        r_rsp_err <= 1'b0;
        if (r_write) r_rsp_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ppwm_cfg_master.sv
// Scoreboard bench for ppwm_cfg_master: stimulus queues expected responses,
// a monitor pops them on rsp_valid; bus framing is checked cycle by cycle.
module tb_ppwm_cfg_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: STROBE_CYCLES = 2
  logic        a_cmd_valid, a_cmd_ready, a_cmd_write;
  logic [7:0]  a_cmd_addr, a_addr;
  logic [31:0] a_cmd_data, a_rsp_data, a_d_out, a_d_in;
  logic        a_rsp_valid, a_rsp_err, a_cs, a_wr, a_rd;

  // Instance B: STROBE_CYCLES = 3
  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [7:0]  b_cmd_addr, b_addr;
  logic [31:0] b_cmd_data, b_rsp_data, b_d_out, b_d_in;
  logic        b_rsp_valid, b_rsp_err, b_cs, b_wr, b_rd;

  ppwm_cfg_master #(.STROBE_CYCLES(2), .ADDR_LIMIT(8'h1C)) u_dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
    .cmd_addr(a_cmd_addr), .cmd_data(a_cmd_data),
    .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_data(a_rsp_data),
    .cs(a_cs), .wr(a_wr), .rd(a_rd), .addr(a_addr), .d_out(a_d_out), .d_in(a_d_in)
  );

  ppwm_cfg_master #(.STROBE_CYCLES(3), .ADDR_LIMIT(8'h1C)) u_dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_data(b_rsp_data),
    .cs(b_cs), .wr(b_wr), .rd(b_rd), .addr(b_addr), .d_out(b_d_out), .d_in(b_d_in)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response scoreboard and bus-framing invariants.
  logic        prev_a_cs = 1'b0, prev_b_cs = 1'b0;
  logic [7:0]  prev_a_addr, prev_b_addr;
  logic [31:0] prev_a_dout, prev_b_dout;

  always @(negedge clk) begin
    if (a_rsp_valid) begin
      if (q_a.size() == 0) check("a_unexpected_rsp", 32'(a_rsp_valid), 32'd0);
      else begin
        e_a = q_a.pop_front();
        check("a_rsp_cycle", 32'(cyc), 32'(e_a.at));
        check("a_rsp_err", 32'(a_rsp_err), 32'(e_a.err));
        check("a_rsp_data", a_rsp_data, e_a.data);
      end
    end
    if (b_rsp_valid) begin
      if (q_b.size() == 0) check("b_unexpected_rsp", 32'(b_rsp_valid), 32'd0);
      else begin
        e_b = q_b.pop_front();
        check("b_rsp_cycle", 32'(cyc), 32'(e_b.at));
        check("b_rsp_err", 32'(b_rsp_err), 32'(e_b.err));
        check("b_rsp_data", b_rsp_data, e_b.data);
      end
    end
    if (a_wr | a_rd) begin
      check("a_strobe_cs", 32'(a_cs), 32'd1);
      check("a_wr_rd_overlap", 32'(a_wr & a_rd), 32'd0);
    end
    if (b_wr | b_rd) begin
      check("b_strobe_cs", 32'(b_cs), 32'd1);
      check("b_wr_rd_overlap", 32'(b_wr & b_rd), 32'd0);
    end
    if (a_cs && prev_a_cs) begin
      check("a_addr_stable", 32'(a_addr), 32'(prev_a_addr));
      check("a_dout_stable", a_d_out, prev_a_dout);
    end
    if (b_cs && prev_b_cs) begin
      check("b_addr_stable", 32'(b_addr), 32'(prev_b_addr));
      check("b_dout_stable", b_d_out, prev_b_dout);
    end
    prev_a_cs = a_cs; prev_a_addr = a_addr; prev_a_dout = a_d_out;
    prev_b_cs = b_cs; prev_b_addr = b_addr; prev_b_dout = b_d_out;
  end

  // Waits (bounded) for cmd_ready while cmd_valid is high; returns the accept cycle.
  task automatic wait_accept_a(output int k, output bit ok);
    ok = 1'b0;
    k  = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (a_cmd_ready) begin ok = 1'b1; k = cyc; end
      else @(negedge clk);
    end
    if (!ok) check("a_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_accept_b(output int k, output bit ok);
    ok = 1'b0;
    k  = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (b_cmd_ready) begin ok = 1'b1; k = cyc; end
      else @(negedge clk);
    end
    if (!ok) check("b_accept_timeout", 32'd0, 32'd1);
  endtask

  // One command on instance A with the full expected bus frame checked per cycle.
  task automatic run_a(input logic wr_i, input logic [7:0] ad, input logic [31:0] dat,
                       input logic exp_err, input logic [31:0] exp_data);
    int   k, last;
    bit   ok;
    logic exp_cs, strobe;
    a_cmd_valid = 1'b1; a_cmd_write = wr_i; a_cmd_addr = ad; a_cmd_data = dat;
    wait_accept_a(k, ok);
    if (!ok) begin a_cmd_valid = 1'b0; return; end
    q_a.push_back('{err: exp_err, data: exp_data, at: (exp_err ? k + 1 : k + 5)});
    @(negedge clk);
    a_cmd_valid = 1'b0; a_cmd_write = ~wr_i; a_cmd_addr = 8'hFF; a_cmd_data = '1;
    last = exp_err ? 2 : 6;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clk);
      exp_cs = !exp_err && (c <= 4);
      strobe = !exp_err && (c >= 2) && (c <= 3);
      check("a_cs", 32'(a_cs), 32'(exp_cs));
      check("a_wr", 32'(a_wr), 32'(strobe & wr_i));
      check("a_rd", 32'(a_rd), 32'(strobe & ~wr_i));
      if (exp_cs) begin
        check("a_addr", 32'(a_addr), 32'(ad));
        check("a_d_out", a_d_out, wr_i ? dat : 32'd0);
      end
      check("a_cmd_ready", 32'(a_cmd_ready), 32'(c == last));
    end
    check("a_rsp_data_hold", a_rsp_data, exp_data);
    check("a_rsp_err_hold", 32'(a_rsp_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  k, k1, k2, low;
    bit  ok, got2;
    a_cmd_valid = 1'b0; a_cmd_write = 1'b0; a_cmd_addr = '0; a_cmd_data = '0; a_d_in = 32'd20;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = '0; b_cmd_data = '0; b_d_in = 32'h0BAD_F00D;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(a_cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(a_rsp_err), 32'd0);
    check("rst_rsp_data", a_rsp_data, 32'd0);
    check("rst_bus", 32'({a_cs, a_wr, a_rd}), 32'd0);
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_d_out", a_d_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("a_ready_after_rst", 32'(a_cmd_ready), 32'd1);
    check("b_ready_after_rst", 32'(b_cmd_ready), 32'd1);

    // Write, read, two illegal addresses (misaligned, above limit), boundary legal
    run_a(1'b1, 8'h00, 32'd1,         1'b0, 32'd0);
    run_a(1'b0, 8'h04, 32'h1234_5678, 1'b0, 32'd20);
    run_a(1'b1, 8'h06, 32'hAAAA_5555, 1'b1, 32'd0);
    run_a(1'b0, 8'h20, 32'd0,         1'b1, 32'd0);
    run_a(1'b0, 8'h1C, 32'd0,         1'b0, 32'd20);
    run_a(1'b1, 8'h1C, 32'hCAFE_0001, 1'b0, 32'd0);

    // Back-to-back writes on the N=3 instance with cmd_valid held
    b_cmd_valid = 1'b1; b_cmd_write = 1'b1; b_cmd_addr = 8'h08; b_cmd_data = 32'h111;
    wait_accept_b(k1, ok);
    if (ok) begin
      q_b.push_back('{err: 1'b0, data: 32'd0, at: k1 + 6});
      @(negedge clk);
      b_cmd_addr = 8'h0C; b_cmd_data = 32'h222;
      low = 0; got2 = 1'b0; k2 = 0;
      for (int t = 0; t < 30 && !got2; t++) begin
        if (!b_cs) low++;
        if (b_cmd_ready) begin got2 = 1'b1; k2 = cyc; end
        else @(negedge clk);
      end
      check("b_second_accept_seen", 32'(got2), 32'd1);
      check("b_accept_gap", 32'(k2 - k1), 32'd7);
      check("b_cs_low_gap", 32'(low), 32'd2);
      if (got2) q_b.push_back('{err: 1'b0, data: 32'd0, at: k2 + 6});
      @(negedge clk);
      b_cmd_valid = 1'b0;
      check("b_second_addr", 32'(b_addr), 32'h0C);
      check("b_second_d_out", b_d_out, 32'h222);
      repeat (8) @(negedge clk);
    end
    b_cmd_valid = 1'b0;

    // Reset during the second STROBE cycle of a write
    a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = 8'h10; a_cmd_data = 32'hDEAD;
    wait_accept_a(k, ok);
    @(negedge clk);
    a_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_in_strobe", 32'(a_wr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs", 32'(a_cs), 32'd0);
    check("abort_wr", 32'(a_wr), 32'd0);
    check("abort_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("abort_ready_in_rst", 32'(a_cmd_ready), 32'd0);
    check("abort_addr", 32'(a_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(a_cmd_ready), 32'd1);
    check("abort_no_rsp", 32'(a_rsp_valid), 32'd0);
    run_a(1'b1, 8'h00, 32'h5A, 1'b0, 32'd0);

    repeat (4) @(negedge clk);
    check("a_queue_empty", 32'(q_a.size()), 32'd0);
    check("b_queue_empty", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
